// File: rtl/branch_unit_ctrl.sv
// branch_unit_ctrl -- branch decision and statistics for the branch stage.
//
// Purpose:
//   Turns the decoded branch flags and the ALU status into the PC-mux select,
//   registers that select and a "more than one branch flag" error for the next
//   stage, and optionally counts evaluated and taken branches.
//
// Optional feature:
//   BRANCH_UNIT_STATS_EN -- when defined, br_cnt/taken_cnt are saturating
//   counters. When undefined they are constant 0 and cnt_clr is ignored.
//
// Ports:
//   clk         in   1      rising-edge clock
//   rst         in   1      asynchronous active-high reset
//   beq_f       in   1      branch-if-equal flag
//   bne_f       in   1      branch-if-not-equal flag
//   bgtz_f      in   1      branch-if-greater-than-zero flag
//   zf          in   1      ALU zero flag
//   msb         in   1      ALU result sign bit
//   en          in   1      pipeline advance (gates all registered updates)
//   cnt_clr     in   1      synchronous clear of the counters
//   br_sel      out  1      combinational branch-taken select
//   br_sel_q    out  1      registered br_sel
//   multi_err_q out  1      registered "two or more flags asserted"
//   br_cnt      out  CNT_W  evaluated branch count (saturating)
//   taken_cnt   out  CNT_W  taken branch count (saturating)

module branch_unit_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             beq_f,
  input  logic             bne_f,
  input  logic             bgtz_f,
  input  logic             zf,
  input  logic             msb,
  input  logic             en,
  input  logic             cnt_clr,
  output logic             br_sel,
  output logic             br_sel_q,
  output logic             multi_err_q,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  logic w_br_sel;
  logic w_multi;
  logic w_any;

  // No priority between flags: each term contributes independently.
  assign w_br_sel = (beq_f & zf) | (bne_f & ~zf) | (bgtz_f & ~zf & ~msb);
  assign w_multi  = (beq_f & bne_f) | (beq_f & bgtz_f) | (bne_f & bgtz_f);
  assign w_any    = beq_f | bne_f | bgtz_f;

  assign br_sel = w_br_sel;

  logic r_br_sel_q;
  logic r_multi_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_br_sel_q    <= 1'b0;
      r_multi_err_q <= 1'b0;
    end else if (en) begin
      r_br_sel_q    <= w_br_sel;
      r_multi_err_q <= w_multi;
    end
  end

  assign br_sel_q    = r_br_sel_q;
  assign multi_err_q = r_multi_err_q;

`ifdef BRANCH_UNIT_STATS_EN
  logic [CNT_W-1:0] r_br_cnt;
  logic [CNT_W-1:0] r_taken_cnt;

  // Clear wins over increment and does not need en; counters stick at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_br_cnt    <= '0;
      r_taken_cnt <= '0;
    end else if (cnt_clr) begin
      r_br_cnt    <= '0;
      r_taken_cnt <= '0;
    end else if (en && w_any) begin
      if (r_br_cnt != {CNT_W{1'b1}})
        r_br_cnt <= r_br_cnt + 1'b1;
      if (w_br_sel && (r_taken_cnt != {CNT_W{1'b1}}))
        r_taken_cnt <= r_taken_cnt + 1'b1;
    end
  end

  assign br_cnt    = r_br_cnt;
  assign taken_cnt = r_taken_cnt;
`else
  // Statistics disabled: constant outputs, clear input deliberately dropped.
  logic w_unused_stats;
  assign w_unused_stats = cnt_clr & w_any;

  assign br_cnt    = '0;
  assign taken_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_unit_ctrl.sv
module tb_branch_unit_ctrl;

  localparam int CNT_W = 8;
`ifdef BRANCH_UNIT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic beq_f, bne_f, bgtz_f, zf, msb, en, cnt_clr;
  logic br_sel, br_sel_q, multi_err_q;
  logic [CNT_W-1:0] br_cnt, taken_cnt;

  branch_unit_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .beq_f(beq_f), .bne_f(bne_f), .bgtz_f(bgtz_f),
    .zf(zf), .msb(msb), .en(en), .cnt_clr(cnt_clr),
    .br_sel(br_sel), .br_sel_q(br_sel_q), .multi_err_q(multi_err_q),
    .br_cnt(br_cnt), .taken_cnt(taken_cnt)
  );

  always #10 clk = ~clk;  // posedges at 10, 30, 50, ...

  typedef struct {
    string      name;
    logic       sel;
    logic       selq;
    logic       merr;
    logic [7:0] bc;
    logic [7:0] tc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // br_sel truth table, index {beq,bne,bgtz,zf,msb}, worked out by hand.
  logic [31:0] sel_tbl;

  // Monitor: whenever an expectation is queued, let the DUT settle and compare.
  initial begin
    exp_t e;
    forever begin
      while (q.size() == 0) #1;
      #1;
      e = q.pop_front();
      checks++;
      if (br_sel !== e.sel) begin
        errors++;
        $display("FAIL %s br_sel: got %b want %b", e.name, br_sel, e.sel);
      end
      checks++;
      if (br_sel_q !== e.selq) begin
        errors++;
        $display("FAIL %s br_sel_q: got %b want %b", e.name, br_sel_q, e.selq);
      end
      checks++;
      if (multi_err_q !== e.merr) begin
        errors++;
        $display("FAIL %s multi_err_q: got %b want %b", e.name, multi_err_q, e.merr);
      end
      checks++;
      if (br_cnt !== e.bc) begin
        errors++;
        $display("FAIL %s br_cnt: got %0d want %0d", e.name, br_cnt, e.bc);
      end
      checks++;
      if (taken_cnt !== e.tc) begin
        errors++;
        $display("FAIL %s taken_cnt: got %0d want %0d", e.name, taken_cnt, e.tc);
      end
    end
  end

  function automatic logic [7:0] c(input int v);
    return STATS ? 8'(v) : 8'd0;
  endfunction

  task automatic expect_now(input string n, input logic s, input logic sq,
                            input logic me, input logic [7:0] bc, input logic [7:0] tc);
    exp_t e;
    int t;
    e.name = n; e.sel = s; e.selq = sq; e.merr = me; e.bc = bc; e.tc = tc;
    q.push_back(e);
    t = 0;
    while (q.size() != 0 && t < 8) begin #1; t++; end
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s monitor_timeout: got pending=%0d want 0", n, q.size());
      q.delete();
    end
  endtask

  task automatic set_in(input logic b1, input logic b2, input logic b3,
                        input logic z, input logic m);
    beq_f = b1; bne_f = b2; bgtz_f = b3; zf = z; msb = m;
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  initial begin
    sel_tbl = 32'hFFDC_3310;
    rst = 1'b1; en = 1'b0; cnt_clr = 1'b0;
    set_in(0, 0, 0, 0, 0);
    #2;
    expect_now("reset_state", 0, 0, 0, 0, 0);

    // br_sel keeps working while in reset; registers stay cleared across an edge.
    set_in(1, 1, 0, 1, 0); en = 1'b1;
    expect_now("rst_comb", 1, 0, 0, 0, 0);
    edge1();
    expect_now("rst_hold_edge", 1, 0, 0, 0, 0);
    rst = 1'b0; en = 1'b0;
    set_in(0, 0, 0, 0, 0);

    // Exhaustive combinational sweep with en=0 so nothing registers.
    for (int i = 0; i < 32; i++) begin
      logic [4:0] v;
      v = 5'(i);
      set_in(v[4], v[3], v[2], v[1], v[0]);
      expect_now($sformatf("sweep_%02h", i), sel_tbl[i], 0, 0, 0, 0);
    end

    // Wait for a clean cycle boundary before sequential tests.
    set_in(0, 0, 0, 0, 0);
    edge1();

    // beq taken registers; en=0 holds despite br_sel=0.
    en = 1'b1; set_in(1, 0, 0, 1, 0);
    edge1();
    expect_now("beq_taken_q", 1, 1, 0, c(1), c(1));
    en = 1'b0; set_in(1, 0, 0, 0, 0);
    edge1();
    expect_now("en0_hold", 0, 1, 0, c(1), c(1));

    // Two flags -> multi error; single flag next -> cleared.
    en = 1'b1; set_in(1, 1, 0, 0, 0);
    edge1();
    expect_now("multi_err_set", 1, 1, 1, c(2), c(2));
    set_in(0, 1, 0, 1, 0);
    edge1();
    expect_now("multi_err_clr", 0, 0, 0, c(3), c(2));

    // No flag: not an evaluated branch.
    set_in(0, 0, 0, 0, 1);
    edge1();
    expect_now("no_flag", 0, 0, 0, c(3), c(2));

    // Clear works with en=0.
    en = 1'b0; cnt_clr = 1'b1;
    edge1();
    cnt_clr = 1'b0;
    expect_now("clr_en0", 0, 0, 0, 0, 0);

    // bgtz positive taken, then asynchronous reset mid-cycle.
    en = 1'b1; set_in(0, 0, 1, 0, 0);
    edge1();
    expect_now("bgtz_taken", 1, 1, 0, c(1), c(1));
    set_in(1, 0, 1, 0, 0);  // multi flags present on the next update
    rst = 1'b1;
    expect_now("async_rst", 1, 0, 0, 0, 0);
    rst = 1'b0;
    set_in(0, 1, 0, 0, 1);
    edge1();
    expect_now("first_after_rst", 1, 1, 0, c(1), c(1));

    // Saturation: 300 more taken branches.
    set_in(1, 0, 0, 1, 0);
    repeat (300) @(posedge clk);
    #1;
    expect_now("saturate", 1, 1, 0, c(255), c(255));

    // Clear overrides a concurrent increment.
    cnt_clr = 1'b1;
    edge1();
    expect_now("clr_over_inc", 1, 1, 0, 0, 0);
    cnt_clr = 1'b0;
    set_in(0, 0, 1, 0, 1);  // bgtz negative: counted, not taken
    edge1();
    expect_now("bgtz_neg", 0, 0, 0, c(1), c(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

endmodule
